// File: rtl/cordic_vec_seq_pkg.sv
// Shared definitions for the sequential CORDIC vectoring engine: the
// arctangent table, the controller states and the CORDIC gain constant.
package cordic_vec_seq_pkg;

  // Iteration index type; wide enough for indices 0..29.
  typedef logic [4:0] iter_idx_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of arctangent entries available (maximum iteration count).
  localparam int ATAN_ENTRIES = 30;

  // round(atan(2^-i) * 2^32 / (2*pi)) as 32-bit binary angles.
  localparam logic [31:0] ATAN_TABLE [ATAN_ENTRIES] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001
  };

  // CORDIC gain K ~= 1.6467602 in Q2.30, for consumers that compensate.
  localparam logic [31:0] K_Q2_30 = 32'h6964_8523;

  // Table lookup; indices past the table end read as zero angle.
  function automatic logic [31:0] atan_lookup(input iter_idx_t idx);
    if (idx < 5'd30) begin
      atan_lookup = ATAN_TABLE[idx];
    end else begin
      atan_lookup = 32'h0000_0000;
    end
  endfunction

endpackage

// File: rtl/cordic_vec_seq_iter.sv
// One combinational CORDIC vectoring micro-rotation with a runtime shift.
// Drives y towards zero while accumulating the rotated angle in z.
module cordic_vec_iter
  import cordic_vec_seq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] z,
  input  iter_idx_t     i,
  output logic [DW-1:0] x_rot,
  output logic [DW-1:0] y_rot,
  output logic [DW-1:0] z_rot
);

  logic [31:0]   atan32_s;
  logic [DW-1:0] atan_s;
  logic [DW-1:0] x_sh_s;
  logic [DW-1:0] y_sh_s;

  // Fetch the 32-bit angle step for this iteration.
  always_comb atan32_s = atan_lookup(i);

  // Rescale the 32-bit binary angle to the datapath width.
  if (DW == 32) begin : g_atan_eq
    assign atan_s = atan32_s;
  end else if (DW > 32) begin : g_atan_wide
    assign atan_s = {atan32_s, {(DW-32){1'b0}}};
  end else begin : g_atan_narrow
    assign atan_s = atan32_s[31 -: DW];
  end

  // Rotate towards y = 0 using pre-update x and y; all sums wrap at DW bits.
  always_comb begin
    x_sh_s = $signed(x) >>> i;
    y_sh_s = $signed(y) >>> i;
    if (!y[DW-1]) begin
      x_rot = x + y_sh_s;
      y_rot = y - x_sh_s;
      z_rot = z + atan_s;
    end else begin
      x_rot = x - y_sh_s;
      y_rot = y + x_sh_s;
      z_rot = z - atan_s;
    end
  end

endmodule

// File: rtl/cordic_vec_seq.sv
// Sequential CORDIC vectoring engine: accepts (x, y), folds the left half
// plane, runs N_ITER micro-rotations through one shared stage and returns
// the gain-scaled magnitude and binary angle with a valid/ready handshake.
module cordic_vec_seq
  import cordic_vec_seq_pkg::*;
#(
  parameter int N_ITER = 16,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          RST_N,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  input  logic [DW-1:0] in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_mag,
  output logic [DW-1:0] out_ang,
  output logic          busy
);

  localparam iter_idx_t LAST_I = 5'(N_ITER - 1);

  state_e        state_r,     state_nxt_s;
  logic [DW-1:0] x_r,         x_nxt_s;
  logic [DW-1:0] y_r,         y_nxt_s;
  logic [DW-1:0] z_r,         z_nxt_s;
  iter_idx_t     i_r,         i_nxt_s;
  logic [DW-1:0] out_mag_r,   mag_nxt_s;
  logic [DW-1:0] out_ang_r,   ang_nxt_s;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;
  logic [DW-1:0] rot_x_s;
  logic [DW-1:0] rot_y_s;
  logic [DW-1:0] rot_z_s;

  cordic_vec_iter #(.DW(DW)) u_iter (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .i     (i_r),
    .x_rot (rot_x_s),
    .y_rot (rot_y_s),
    .z_rot (rot_z_s)
  );

  // Next-state and datapath update for the IDLE/PRE/ITER/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    z_nxt_s     = z_r;
    i_nxt_s     = i_r;
    mag_nxt_s   = out_mag_r;
    ang_nxt_s   = out_ang_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          x_nxt_s     = in_x;
          y_nxt_s     = in_y;
          z_nxt_s     = {DW{1'b0}};
          i_nxt_s     = 5'd0;
          state_nxt_s = ST_PRE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        // Left half plane: rotate by 180 deg so iterations converge.
        if (x_r[DW-1]) begin
          x_nxt_s = -x_r;
          y_nxt_s = -y_r;
          z_nxt_s = {1'b1, {(DW-1){1'b0}}};
        end else begin
          z_nxt_s = {DW{1'b0}};
        end
        i_nxt_s     = 5'd0;
        state_nxt_s = ST_ITER;
      end
      ST_ITER: begin
        x_nxt_s = rot_x_s;
        y_nxt_s = rot_y_s;
        z_nxt_s = rot_z_s;
        if (i_r == LAST_I) begin
          i_nxt_s     = 5'd0;
          mag_nxt_s   = rot_x_s;
          ang_nxt_s   = rot_z_s;
          state_nxt_s = ST_DONE;
        end else begin
          i_nxt_s     = i_r + 5'd1;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; async clear to zero.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      x_r         <= {DW{1'b0}};
      y_r         <= {DW{1'b0}};
      z_r         <= {DW{1'b0}};
      i_r         <= 5'd0;
      out_mag_r   <= {DW{1'b0}};
      out_ang_r   <= {DW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      x_r         <= x_nxt_s;
      y_r         <= y_nxt_s;
      z_r         <= z_nxt_s;
      i_r         <= i_nxt_s;
      out_mag_r   <= mag_nxt_s;
      out_ang_r   <= ang_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_mag   = out_mag_r;
  assign out_ang   = out_ang_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cordic_vec_seq.sv
// Scoreboard bench for cordic_vec_seq: stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_cordic_vec_seq;

  localparam int N_ITER = 16;
  localparam int DW     = 32;

  logic          clk = 1'b0;
  logic          RST_N;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_mag;
  logic [DW-1:0] out_ang;
  logic          busy;

  cordic_vec_seq #(.N_ITER(N_ITER), .DW(DW)) dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_ang   (out_ang),
    .busy      (busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mag;
    logic [31:0] ang;
    int          mag_tol;
    int          ang_tol;
    bit          chk_ang;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          acc_list[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] bt [30];

  // Free-running cycle counter used for latency and spacing measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [31:0] act, input logic [31:0] req, input int tol);
    logic signed [31:0] d;
    longint ad;
    d  = act - req;
    ad = (d < 0) ? -longint'(d) : longint'(d);
    n_checks++;
    if (ad > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h +/- %0d", nm, act, req, tol);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] m, input logic [31:0] a, input int mt,
                              input int at, input bit ca, input string nm);
    exp_t e;
    e.mag = m; e.ang = a; e.mag_tol = mt; e.ang_tol = at; e.chk_ang = ca; e.name = nm;
    return e;
  endfunction

  // Reference vectoring CORDIC using a table derived from real arithmetic.
  function automatic void model(input logic [31:0] ix, input logic [31:0] iy,
                                output logic [31:0] m, output logic [31:0] a);
    logic signed [31:0] x, y, xs, ys;
    logic [31:0] z;
    x = ix; y = iy; z = 32'h0;
    if (x < 0) begin
      x = -x; y = -y; z = 32'h8000_0000;
    end
    for (int k = 0; k < N_ITER; k++) begin
      xs = x >>> k;
      ys = y >>> k;
      if (y >= 0) begin
        x = x + ys; y = y - xs; z = z + bt[k];
      end else begin
        x = x - ys; y = y + xs; z = z - bt[k];
      end
    end
    m = x; a = z;
  endfunction

  // Present one vector once in_ready is seen; optionally queue its expectation.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input bit push, input exp_t e);
    int tries;
    tries = 0;
    @(negedge clk);
    while (!in_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready got 0, required 1");
    end else begin
      in_x = x; in_y = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      acc_list.push_back(cyc);
      if (push) sb_q.push_back(e);
    end
  endtask

  // Wait until all queued results are consumed and the block is idle again.
  task automatic wait_idle();
    int tries;
    tries = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || !in_ready) && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (sb_q.size() != 0 || !in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: pending %0d in_ready %0d, required 0 and 1", sb_q.size(), in_ready);
    end
  endtask

  // Monitor: latency on each out_valid rise, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (!RST_N) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        chk_eq("latency", 32'(cyc - acc_cyc + 1), 32'(N_ITER + 2));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: got mag 0x%08h ang 0x%08h, required no result", out_mag, out_ang);
        end else begin
          mon_e = sb_q.pop_front();
          chk_tol({mon_e.name, "_mag"}, out_mag, mon_e.mag, mon_e.mag_tol);
          if (mon_e.chk_ang) begin
            chk_tol({mon_e.name, "_ang"}, out_ang, mon_e.ang, mon_e.ang_tol);
          end
        end
      end
      prev_valid <= out_valid;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] em, ea;
    logic [31:0] bx [4];
    logic [31:0] by [4];
    int   tries;
    bit   seen;

    for (int k = 0; k < 30; k++) begin
      bt[k] = 32'($rtoi($atan(1.0 / (2.0 ** k)) * 4294967296.0 / (2.0 * 3.14159265358979323846) + 0.5));
    end

    RST_N = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_x = 32'h0; in_y = 32'h0;
    #2 RST_N = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_out_valid", out_valid, 1'b0);
    chk_eq("rst_out_mag", out_mag, 32'h0);
    chk_eq("rst_out_ang", out_ang, 32'h0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #2 RST_N = 1'b1;
    @(negedge clk);
    chk_eq("in_ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    chk_eq("in_ready_after_edge", in_ready, 1'b1);

    // Directed vectors with hand-derived expectations.
    send(32'h0001_0000, 32'h0000_0000, 1'b1, mk(32'h0001_A592, 32'h0000_0000, 4, 1 << 18, 1'b1, "x_axis"));
    wait_idle();
    send(32'h0000_0000, 32'h0001_0000, 1'b1, mk(32'h0001_A592, 32'h4000_0000, 8, 1 << 18, 1'b1, "y_axis"));
    wait_idle();
    send(32'hFFFF_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h0001_A592, 32'h8000_0000, 8, 1 << 18, 1'b1, "neg_x"));
    wait_idle();
    send(32'h0000_0000, 32'h0000_0000, 1'b1, mk(32'h0000_0000, 32'h0, 0, 0, 1'b0, "zero"));
    wait_idle();

    // Hold result with out_ready low; a second request must be ignored.
    out_ready = 1'b0;
    model(32'h0000_3000, 32'h0000_4000, em, ea);
    send(32'h0000_3000, 32'h0000_4000, 1'b1, mk(em, ea, 0, 0, 1'b1, "hold"));
    tries = 0;
    while (!out_valid && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    chk_eq("hold_valid_seen", out_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_eq("hold_mag", out_mag, em);
      chk_eq("hold_ang", out_ang, ea);
      chk_eq("hold_in_ready", in_ready, 1'b0);
      if (k == 3) begin
        in_x = 32'h0700_0000; in_y = 32'h0100_0000; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (busy || out_valid) seen = 1'b1;
    end
    chk_eq("second_pulse_ignored", seen, 1'b0);

    // Reset during iteration 7 discards the vector in flight.
    send(32'h0000_5000, 32'h0000_1000, 1'b0, mk(32'h0, 32'h0, 0, 0, 1'b0, "discard"));
    repeat (8) @(posedge clk);
    #2 RST_N = 1'b0;
    @(negedge clk);
    chk_eq("midrst_out_valid", out_valid, 1'b0);
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #2 RST_N = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_eq("midrst_in_ready_after", in_ready, 1'b1);
    model(32'h0000_2000, 32'hFFFF_9000, em, ea);
    send(32'h0000_2000, 32'hFFFF_9000, 1'b1, mk(em, ea, 0, 0, 1'b1, "after_rst"));
    wait_idle();

    // Back-to-back vectors with out_ready high: exact results, fixed spacing.
    bx[0] = 32'h0123_4567; by[0] = 32'hFF89_ABCE;
    bx[1] = 32'hFF54_3211; by[1] = 32'h00FE_DCBA;
    bx[2] = 32'h1000_0000; by[2] = 32'h0800_0000;
    bx[3] = 32'hF000_0001; by[3] = 32'hF800_0000;
    acc_list.delete();
    for (int k = 0; k < 4; k++) begin
      model(bx[k], by[k], em, ea);
      send(bx[k], by[k], 1'b1, mk(em, ea, 0, 0, 1'b1, $sformatf("b2b%0d", k)));
    end
    wait_idle();
    for (int k = 1; k < 4; k++) begin
      if (k < acc_list.size()) begin
        chk_eq("b2b_spacing", 32'(acc_list[k] - acc_list[k-1]), 32'(N_ITER + 3));
      end else begin
        n_checks++; n_fail++;
        $display("FAIL b2b_accepts: got %0d accepts, required 4", acc_list.size());
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_vec_seq.md
CORDIC_VEC_SEQ -- requirements
Module: cordic_vec_seq

Interface
REQ-001 SHALL have parameter N_ITER, default 16; number of micro-rotations per vector, legal range 1..30.
REQ-002 SHALL have parameter DW, default 32; datapath width for x, y and z.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input vector present.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 in_x  input  DW  signed x component.
REQ-008 in_y  input  DW  signed y component.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_mag  output  DW  signed magnitude times CORDIC gain K (about 1.6468), no gain compensation.
REQ-012 out_ang  output  DW  binary angle; 2^DW represents 360 deg, 0x4000_0000 represents 90 deg, wraps modulo 2^DW.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, PRE, ITER and DONE.
REQ-015 in_ready SHALL be high only in IDLE; an accept occurs on a cycle with in_valid and in_ready both high.
REQ-016 On accept, the FSM SHALL capture in_x and in_y into internal registers x and y and go IDLE -> PRE.
REQ-017 In PRE, SHALL fold the quadrant:
- if x<0: x=-x, y=-y, z=0x8000_0000;
- else: z=0.
Then the FSM SHALL go PRE -> ITER with iteration counter i=0.
REQ-018 In ITER, SHALL perform one vectoring micro-rotation per cycle:
- if y>=0 (sign bit clear): x+=y>>>i, y-=x>>>i, z+=ATAN[i];
- else: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
All right-hand sides SHALL use the pre-update values.
REQ-019 Shifts SHALL be arithmetic; x and y adds SHALL wrap at DW bits; z SHALL wrap modulo 2^DW.
REQ-020 ITER SHALL exit to DONE after the iteration with i=N_ITER-1, and register out_mag=x and out_ang=z on that transition.
REQ-021 In DONE, out_valid SHALL be high, and out_mag and out_ang SHALL be held stable until out_ready is sampled high.
REQ-022 The DONE -> IDLE transition SHALL occur on the cycle out_valid and out_ready are both high.
REQ-023 Latency SHALL be N_ITER+2 cycles from the accept edge to out_valid high (18 cycles for the default).
REQ-024 Throughput SHALL be one vector per N_ITER+3 cycles or more; there is no overlap between vectors.
REQ-025 in_valid while busy SHALL be ignored; the input is not captured.
REQ-026 The caller SHALL keep |in_x| and |in_y| below 2^(DW-3); results outside that range are undefined but SHALL NOT hang the FSM.
REQ-027 Input x=y=0 SHALL complete normally with out_mag=0.

Reset
REQ-028 Asserting RST_N low SHALL force, asynchronously, state=IDLE, i=0 and all registers to 0, at any point including mid-ITER or DONE.
REQ-029 During reset the outputs SHALL be: out_valid=0, out_mag=0, out_ang=0, busy=0, in_ready=0.
REQ-030 in_ready SHALL rise on the first clock edge after RST_N deasserts.
REQ-031 A result in progress at reset SHALL be discarded; no out_valid pulse is produced for it.

Structure
REQ-032 A shared package SHALL hold:
- the ATAN table as 30 DW-bit binary-angle constants, round(atan(2^-i)*2^DW/(2*pi)), with ATAN[0]=0x2000_0000;
- the state enum;
- the gain constant K in Q2.30 for consumers.
REQ-033 A single sub-module cordic_vec_iter SHALL implement one micro-rotation, combinational, with a runtime shift amount i; the FSM SHALL instantiate it once and feed its outputs back into the x, y and z registers.

Verification
REQ-034 The bench SHALL cover in_x=0x0001_0000, in_y=0 -> out_mag=0x0001_A592 (+/-4 LSB), out_ang=0 (+/-2^18), out_valid at cycle 18.
REQ-035 The bench SHALL cover in_x=0, in_y=0x0001_0000 -> out_ang=0x4000_0000 (+/-2^18), out_mag about 0x0001_A592.
REQ-036 The bench SHALL cover in_x=-0x0001_0000, in_y=-1 -> out_ang within 2^18 of 0x8000_0000 (either side; wrap accepted).
REQ-037 The bench SHALL cover out_ready held low for 10 cycles in DONE -> outputs stable, in_ready=0; a second in_valid pulse meanwhile is not captured.
REQ-038 The bench SHALL cover RST_N pulsed low at iteration 7 -> out_valid stays 0, in_ready=1 after release, and a next vector completes correctly.
REQ-039 The bench SHALL cover back-to-back vectors with out_ready tied high -> accepts spaced exactly N_ITER+3 cycles apart, results matching a reference model bit-exactly.
